// File: rtl/regfile_sweep.sv
// regfile_sweep: DEPTH x WIDTH register file with two combinational read
// ports, one synchronous write port, optional hardwired-zero r0, optional
// write-to-read bypass, and a sweep FSM that zeroes the array after reset
// or on a clear request, holding ready low until the array is clean.
module regfile_sweep #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [AW-1:0]    readreg1,
  input  logic [AW-1:0]    readreg2,
  input  logic [AW-1:0]    writereg,
  input  logic [WIDTH-1:0] writedata,
  input  logic             RegWrite,
  output logic [WIDTH-1:0] readdata1,
  output logic [WIDTH-1:0] readdata2,
  output logic             ready
);

  // One extra bit so DEPTH itself is representable when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_X  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            ready_q, ready_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             mem_we_c;
  logic [AW-1:0]    mem_waddr_c;
  logic [WIDTH-1:0] mem_wdata_c;
  logic             wr_legal_c;

  // Index lies inside the array (non-power-of-two DEPTH must not alias).
  function automatic logic in_range(input logic [AW-1:0] idx);
    return ({1'b0, idx} < DEPTH_X);
  endfunction

  // Index names the hardwired-zero register.
  function automatic logic is_zero_reg(input logic [AW-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Value seen on one read port, in priority order.
  function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] idx);
    logic [WIDTH-1:0] val;
    val = '0;
    if (!ready_q || !in_range(idx) || is_zero_reg(idx)) begin
      val = '0;
    end else if ((BYPASS != 0) && wr_legal_c && (writereg == idx)) begin
      val = writedata;
    end else begin
      val = mem_q[idx];
    end
    return val;
  endfunction

  // A write that will actually land in the array on the next edge.
  always_comb begin
    wr_legal_c = (state_q == ST_RUN) && RegWrite && !clear &&
                 in_range(writereg) && !is_zero_reg(writereg);
  end

  // Sweep FSM next-state and array write-port selection.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ready_d     = ready_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = ptr_q;
    mem_wdata_c = '0;
    unique case (state_q)
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = ptr_q;
        if (clear) begin
          ptr_d = '0;
        end else if (ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
          ready_d = 1'b0;
        end else if (wr_legal_c) begin
          mem_we_c    = 1'b1;
          mem_waddr_c = writereg;
          mem_wdata_c = writedata;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  // FSM state, sweep pointer and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Array storage; not reset, and no write lands while rst is held.
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Combinational read ports.
  always_comb begin
    readdata1 = read_port(readreg1);
    readdata2 = read_port(readreg2);
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Bench for regfile_sweep: two instances (32x32 with zero-reg and bypass,
// 24x16 with neither) driven by the same stimulus; expected read data and
// ready are queued by the driver and checked by an independent monitor.
module tb_regfile_sweep;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  rr1 = '0;
  logic [4:0]  rr2 = '0;
  logic [4:0]  wr = '0;
  logic [31:0] wd = '0;

  logic [31:0] rd1_a, rd2_a;
  logic        rdy_a;
  logic [15:0] rd1_b, rd2_b;
  logic        rdy_b;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  regfile_sweep #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .clear(clear),
    .readreg1(rr1), .readreg2(rr2), .writereg(wr),
    .writedata(wd), .RegWrite(we),
    .readdata1(rd1_a), .readdata2(rd2_a), .ready(rdy_a)
  );

  regfile_sweep #(.WIDTH(16), .DEPTH(24), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .clear(clear),
    .readreg1(rr1), .readreg2(rr2), .writereg(wr),
    .writedata(wd[15:0]), .RegWrite(we),
    .readdata1(rd1_b), .readdata2(rd2_b), .ready(rdy_b)
  );

  // Reference model: k=0 is dut_a, k=1 is dut_b.
  logic [31:0] mem_m [2][32];
  int          busy_m [2] = '{32, 24};

  function automatic int dep(input int k);  return (k == 0) ? 32 : 24; endfunction
  function automatic bit zr(input int k);   return (k == 0);           endfunction
  function automatic bit byp(input int k);  return (k == 0);           endfunction
  function automatic logic [31:0] msk(input int k);
    return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  task automatic model_reset(input int k);
    busy_m[k] = dep(k);
    for (int i = 0; i < 32; i++) mem_m[k][i] = '0;
  endtask

  function automatic logic [31:0] exp_read(input int k, input int idx, input logic w,
                                           input logic c, input int wa, input logic [31:0] d);
    if (busy_m[k] != 0) return '0;
    if (idx >= dep(k)) return '0;
    if (zr(k) && idx == 0) return '0;
    if (byp(k) && w && !c && wa == idx) return d & msk(k);
    return mem_m[k][idx];
  endfunction

  task automatic model_edge(input int k, input logic r, input logic c, input logic w,
                            input int wa, input logic [31:0] d);
    if (r) begin
      model_reset(k);
    end else if (busy_m[k] != 0) begin
      if (c) busy_m[k] = dep(k);
      else   busy_m[k] = busy_m[k] - 1;
    end else if (c) begin
      model_reset(k);
    end else if (w && wa < dep(k) && !(zr(k) && wa == 0)) begin
      mem_m[k][wa] = d & msk(k);
    end
  endtask

  typedef struct {
    logic [31:0] e1a, e2a, e1b, e2b;
    logic        ea, eb;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue its expectation.
  task automatic drive(input logic r, input logic c, input logic w, input int wa,
                       input logic [31:0] d, input int a1, input int a2);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; we = w; wr = 5'(wa); wd = d; rr1 = 5'(a1); rr2 = 5'(a2);
    if (r) begin
      model_reset(0);
      model_reset(1);
    end
    e.e1a = exp_read(0, a1, w, c, wa, d);
    e.e2a = exp_read(0, a2, w, c, wa, d);
    e.e1b = exp_read(1, a1, w, c, wa, d);
    e.e2b = exp_read(1, a2, w, c, wa, d);
    e.ea  = (busy_m[0] == 0);
    e.eb  = (busy_m[1] == 0);
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic r, input logic c, input logic w, input int wa,
                     input logic [31:0] d, input int a1, input int a2);
    drive(r, c, w, wa, d, a1, a2);
    model_edge(0, r, c, w, wa, d);
    model_edge(1, r, c, w, wa, d);
  endtask

  // Monitor: the DUT presents settled outputs every cycle before the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rdy_a", 32'(rdy_a), 32'(e.ea));
        chk("rd1_a", rd1_a, e.e1a);
        chk("rd2_a", rd2_a, e.e2a);
        chk("rdy_b", 32'(rdy_b), 32'(e.eb));
        chk("rd1_b", 32'(rd1_b), e.e1b);
        chk("rd2_b", 32'(rd2_b), e.e2b);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    model_reset(0);
    model_reset(1);

    // Power-up reset, then sweep: ready rises on edge 32 (a) / 24 (b).
    cyc(1, 0, 0, 0, 0, 1, 31);
    cyc(1, 0, 0, 0, 0, 1, 31);
    for (int i = 0; i < 34; i++) cyc(0, 0, 1, 5, 32'h1111_1111, 1, 31);

    // Basic write/read and hardwired zero.
    cyc(0, 0, 1, 5, 32'hDEAD_BEEF, 0, 0);
    cyc(0, 0, 0, 0, 0, 5, 5);
    cyc(0, 0, 1, 0, 32'hFFFF_FFFF, 0, 5);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Same-cycle bypass on a, old value on b.
    cyc(0, 0, 1, 7, 32'h0BAD_0BAD, 0, 0);
    cyc(0, 0, 1, 7, 32'h1234_5678, 7, 7);
    cyc(0, 0, 0, 0, 0, 7, 5);

    // Fill, then clear together with a dropped write to r3.
    for (int i = 1; i < 32; i++) cyc(0, 0, 1, i, $urandom | 32'h1, i, 32 - i);
    cyc(0, 1, 1, 3, 32'hAAAA_5555, 3, 3);
    for (int i = 0; i < 33; i++) cyc(0, 0, 1, 3, 32'h5555_AAAA, 3, 4);
    for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0, i, 31 - i);

    // Async reset mid-clock at sweep pointer 10.
    for (int i = 1; i < 32; i++) cyc(0, 0, 1, i, $urandom, i, 0);
    cyc(0, 1, 0, 0, 0, 1, 2);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 1, 2);
    drive(0, 0, 1, 9, 32'h7777_7777, 9, 2);
    #3 rst = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    chk("async_rdy_a", 32'(rdy_a), 32'd0);
    chk("async_rdy_b", 32'(rdy_b), 32'd0);
    chk("async_rd1_a", rd1_a, 32'd0);
    cyc(1, 0, 0, 0, 0, 9, 2);
    for (int i = 0; i < 33; i++) cyc(0, 0, 0, 0, 0, 9, 31);

    // Out-of-range index for the 24-deep instance.
    cyc(0, 0, 1, 30, 32'hCAFE_F00D, 30, 23);
    cyc(0, 0, 1, 23, 32'h0000_BEEF, 30, 23);
    cyc(0, 0, 0, 0, 0, 30, 23);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      int wa;
      logic w, c;
      wa = int'($urandom_range(0, 31));
      w  = (($urandom % 10) < 6);
      c  = (($urandom % 50) == 0);
      a  = (($urandom % 4) == 0) ? wa : int'($urandom_range(0, 31));
      cyc(0, c, w, wa, $urandom, a, int'($urandom_range(0, 31)));
    end

    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sweep.md
# regfile_sweep

Parametrised successor to the CPU register file: a DEPTH x WIDTH array with two combinational read ports, one synchronous write port, optional hardwired-zero register 0, and optional same-cycle write-to-read bypass. Contents are not preloaded from a file. After reset, or on a `clear` request, a sweep state machine zeroes every entry, one per cycle, and holds `ready` low until the array is clean. It sits in the decode stage of the datapath, feeding the ALU operand muxes, with write-back from the last stage.

## Interface
- `WIDTH`, 32, data width in bits (>= 1)
- `DEPTH`, 32, number of registers (>= 2; need not be a power of two)
- `AW`, `$clog2(DEPTH)`, register-index width (derived; do not override)
- `ZERO_REG`, 1, 1 = register 0 always reads 0 and ignores writes
- `BYPASS`, 1, 1 = a read of the register being written this cycle returns `writedata`

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `clear`  in  1  synchronous request to re-zero the whole array
- `readreg1`  in  AW  read index, port 1
- `readreg2`  in  AW  read index, port 2
- `writereg`  in  AW  write index
- `writedata`  in  WIDTH  write data
- `RegWrite`  in  1  write enable
- `readdata1`  out  WIDTH  read data, port 1 (combinational)
- `readdata2`  out  WIDTH  read data, port 2 (combinational)
- `ready`  out  1  1 = array valid and accepting writes

## Operation
- States: CLEAR and RUN. A sweep pointer `ptr` of width AW runs 0..DEPTH-1.
- `rst` asserted: immediately state=CLEAR, `ptr`=0, `ready`=0. The array itself is not reset asynchronously.
- CLEAR, each edge: `mem[ptr]`<=0.
  - If `ptr`==DEPTH-1: go to RUN, `ready`<=1.
  - Otherwise: `ptr`<=`ptr`+1.
  - `RegWrite` is ignored.
- RUN, edge with `clear`=1: go to CLEAR, `ptr`<=0, `ready`<=0. A write in that same cycle is dropped (`clear` has priority).
- RUN, edge with `clear`=0 and `RegWrite`=1: `mem[writereg]`<=`writedata`, unless either of these holds:
  - ZERO_REG=1 and `writereg`==0
  - `writereg`>=DEPTH
- `clear`=1 during CLEAR: restart the sweep (`ptr`<=0).
- Read port n, evaluated in this priority order:
  - `ready`=0 -> 0.
  - `readregn`>=DEPTH -> 0.
  - ZERO_REG=1 and `readregn`==0 -> 0.
  - BYPASS=1, `RegWrite`=1, `clear`=0, `writereg`==`readregn`, and the write is legal -> `writedata`.
  - Otherwise -> `mem[readregn]`.
- Both ports may address the same register; each obeys the rules above independently.

## Timing
- Reset values: `ready`=0, `readdata1`=`readdata2`=0, state CLEAR, `ptr`=0.
- Clear latency: `ready` rises on the DEPTH-th rising edge after `rst` deasserts, or after the edge that sampled `clear`. Default: 32 edges.
- Write latency: data is visible through the array on the read ports after the writing edge.
- With BYPASS=1, data is also visible combinationally in the write cycle itself.
- Read latency: 0 cycles, purely combinational from index and array.
- `rst` asserted mid-sweep or mid-write: the write is lost and the sweep restarts from 0.
- Non-power-of-two DEPTH: the sweep ends at DEPTH-1; out-of-range indices never alias.

## Test plan
- Release `rst`, then count edges: `ready` stays 0 for 31 edges, goes 1 on edge 32; reads of r1/r31 give 0 throughout.
- In RUN, write r5=0xDEADBEEF; next cycle read r5 on both ports -> 0xDEADBEEF. Write r0=0xFFFFFFFF -> r0 still reads 0 (ZERO_REG=1).
- BYPASS=1: write r7=0x12345678 with `readreg1`=7 in the same cycle -> `readdata1`=0x12345678 before the edge. With BYPASS=0 -> old value.
- Fill r1..r31 with nonzero values, pulse `clear` together with a write to r3 -> write dropped, `ready` low 32 cycles, then every register reads 0.
- Assert `rst` asynchronously mid-clock during the sweep at `ptr`=10 -> `ready`=0 at once; the full 32-cycle sweep repeats after release.
- DEPTH=24, WIDTH=16: write to index 30 is ignored, read of index 30 gives 0, and the sweep completes in 24 edges.
